// File: rtl/mbist_mem_collar_pkg.sv
// rtl/mbist_mem_collar_pkg.sv - shared widths, state and compare-tag types for the pmbist memory collar
package mbist_mem_collar_pkg;

    localparam int BG_DATA_DEF    = 2;
    localparam int ADDR_X_DEF     = 2;
    localparam int ADDR_Y_DEF     = 2;
    localparam int FAIL_CNT_W_DEF = 4;
    localparam int RESULT_W       = BG_DATA_DEF + ADDR_X_DEF + ADDR_Y_DEF + FAIL_CNT_W_DEF + 1;

    typedef enum logic [1:0] {
        C_IDLE,
        C_TEST,
        C_DRAIN,
        C_LOADED
    } t_collar_state;

    typedef struct packed {
        logic                               vld;
        logic [ADDR_X_DEF+ADDR_Y_DEF-1:0]   addr;
        logic [BG_DATA_DEF-1:0]             data;
    } t_cmp_tag;

endpackage

// File: rtl/mbist_delay_pipe.sv
// rtl/mbist_delay_pipe.sv - fixed-depth register pipe aligning compare tags with memory read latency
module mbist_delay_pipe #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mbist_mem_collar.sv
// rtl/mbist_mem_collar.sv - per-memory MBIST responder: port mux, latency-aligned compare, fail status and result chain
module mbist_mem_collar
    import mbist_mem_collar_pkg::*;
#(
    parameter int BG_DATA    = BG_DATA_DEF,
    parameter int ADDR_X     = ADDR_X_DEF,
    parameter int ADDR_Y     = ADDR_Y_DEF,
    parameter int READ_LAT   = 1,
    parameter int FAIL_CNT_W = FAIL_CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_mbist_run,
    input  logic [ADDR_X-1:0]        i_addr_x,
    input  logic [ADDR_Y-1:0]        i_addr_y,
    input  logic [BG_DATA-1:0]       i_data,
    input  logic                     i_cs,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic                     i_comp_en,
    input  logic                     i_shift_result,
    input  logic                     i_si,
    output logic                     o_so,
    output logic                     o_fail_flag,
    input  logic [ADDR_X+ADDR_Y-1:0] i_fn_addr,
    input  logic [BG_DATA-1:0]       i_fn_din,
    input  logic                     i_fn_cs,
    input  logic                     i_fn_we,
    output logic [ADDR_X+ADDR_Y-1:0] o_mem_addr,
    output logic [BG_DATA-1:0]       o_mem_din,
    output logic                     o_mem_cs,
    output logic                     o_mem_we,
    input  logic [BG_DATA-1:0]       i_mem_dout
);

    localparam int AW = ADDR_X + ADDR_Y;
    localparam int RW = BG_DATA + AW + FAIL_CNT_W + 1;
    localparam int DW = $clog2(READ_LAT + 1);

    t_collar_state          state_q, state_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic                   run_q, run_d;
    logic                   fail_q, fail_d;
    logic [FAIL_CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]          ff_addr_q, ff_addr_d;
    logic [BG_DATA-1:0]     ff_xor_q, ff_xor_d;
    logic [RW-1:0]          shreg_q, shreg_d;

    t_cmp_tag               tag_in, tag_out;
    logic                   test_sel;
    logic                   run_rise;
    logic                   mismatch;

    assign test_sel = (state_q == C_TEST) || (state_q == C_DRAIN);
    assign run_rise = i_mbist_run & ~run_q;

    assign o_mem_addr = test_sel ? {i_addr_x, i_addr_y} : i_fn_addr;
    assign o_mem_din  = test_sel ? i_data : i_fn_din;
    assign o_mem_cs   = test_sel ? i_cs : i_fn_cs;
    assign o_mem_we   = test_sel ? (i_we & i_cs) : i_fn_we;

    // Only reads issued while the test is live enter the pipe; writes never compare.
    always_comb begin
        tag_in.vld  = i_cs & i_re & i_comp_en & (state_q == C_TEST);
        tag_in.addr = {i_addr_x, i_addr_y};
        tag_in.data = i_data;
    end

    mbist_delay_pipe #(
        .W     ($bits(t_cmp_tag)),
        .DEPTH (READ_LAT)
    ) u_delay_pipe (
        .clk  (clk),
        .rstn (rstn),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign mismatch = tag_out.vld & test_sel & (i_mem_dout != tag_out.data);

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        run_d     = i_mbist_run;
        fail_d    = fail_q;
        cnt_d     = cnt_q;
        ff_addr_d = ff_addr_q;
        ff_xor_d  = ff_xor_q;
        shreg_d   = shreg_q;

        if (i_shift_result) begin
            shreg_d = {i_si, shreg_q[RW-1:1]};
        end

        if (mismatch) begin
            fail_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (!fail_q) begin
                ff_addr_d = tag_out.addr;
                ff_xor_d  = i_mem_dout ^ tag_out.data;
            end
        end

        // State actions come last so a run-start clear or a result load overrides the above.
        case (state_q)
            C_IDLE, C_LOADED: begin
                if (run_rise) begin
                    state_d   = C_TEST;
                    fail_d    = 1'b0;
                    cnt_d     = '0;
                    ff_addr_d = '0;
                    ff_xor_d  = '0;
                    shreg_d   = '0;
                end
            end
            C_TEST: begin
                if (!i_mbist_run) begin
                    state_d = C_DRAIN;
                    drain_d = DW'(READ_LAT);
                end
            end
            C_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = C_LOADED;
                    shreg_d = {ff_xor_q, ff_addr_q, cnt_q, fail_q};
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= C_IDLE;
            drain_q   <= '0;
            run_q     <= 1'b0;
            fail_q    <= 1'b0;
            cnt_q     <= '0;
            ff_addr_q <= '0;
            ff_xor_q  <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            run_q     <= run_d;
            fail_q    <= fail_d;
            cnt_q     <= cnt_d;
            ff_addr_q <= ff_addr_d;
            ff_xor_q  <= ff_xor_d;
            shreg_q   <= shreg_d;
        end
    end

    assign o_so        = shreg_q[0];
    assign o_fail_flag = fail_q;

endmodule
